cheby_sbus_master: RTL and testbench
====================================

CHEBY_SBUS_MASTER -- requirements
Module: cheby_sbus_master

Interface
REQ-001 Parameter ADDR_WIDTH, 3: byte-address width; bus word address is bits [ADDR_WIDTH-1:2].
REQ-002 Parameter TIMEOUT, 255: maximum wait cycles for a Done pulse; legal range 1..65535.
REQ-003 Clk  in  1  single clock; all logic rising-edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-007 cmd_wr  in  1  1 = write, 0 = read.
REQ-008 cmd_dbl  in  1  1 = 64-bit access (two words), 0 = 32-bit access.
REQ-009 cmd_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
REQ-010 cmd_wdata  in  64  write data.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-013 rsp_rdata  out  64  read data.
REQ-014 rsp_err  out  1  timeout occurred.
REQ-015 VMEAddr  out  [ADDR_WIDTH-1:2]  bus word address.
REQ-016 VMEWrData  out  32  bus write data.
REQ-017 VMERdData  in  32  bus read data, valid with VMERdDone.
REQ-018 VMERdMem / VMEWrMem  out  1 each  single-cycle read/write strobes.
REQ-019 VMERdDone / VMEWrDone  in  1 each  single-cycle completion pulses from the responder.

Function
REQ-020 FSM states: IDLE, STROBE, WAIT, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-021 Command accept: IDLE->STROBE; latch cmd_wr, cmd_dbl, cmd_addr and cmd_wdata.
REQ-022 STROBE lasts exactly one cycle: assert VMEWrMem (write) or VMERdMem (read), never both; STROBE->WAIT.
REQ-023 VMEAddr and VMEWrData SHALL be driven from the STROBE cycle and held stable until the matching Done is sampled.
REQ-024 WAIT: only the Done matching the access type completes the word; the other Done, and any Done in IDLE/STROBE/RESP, SHALL be ignored.
REQ-025 Word order for 64-bit: first word at cmd_addr[ADDR_WIDTH-1:2] carries bits [63:32], second word at that address +1 (modulo 2^(ADDR_WIDTH-2)) carries bits [31:0].
REQ-026 Read capture: VMERdData latched in the cycle VMERdDone=1 into the half selected by REQ-025.
REQ-027 32-bit access: write uses cmd_wdata[31:0]; read returns data in rsp_rdata[31:0] with [63:32]=0.
REQ-028 After first-word Done with cmd_dbl=1: WAIT->STROBE for the second word (next strobe one cycle after Done); otherwise WAIT->RESP.
REQ-029 Timeout counter cleared on every STROBE and incremented each WAIT cycle; when it reaches TIMEOUT with no matching Done: rsp_err=1, second word skipped, uncaptured read halves=0, WAIT->RESP.
REQ-030 A Done arriving in the same cycle the counter reaches TIMEOUT SHALL win; no error is flagged.
REQ-031 RESP: rsp_valid=1 with rsp_rdata and rsp_err held stable until rsp_ready=1, then ->IDLE; rsp_ready=1 in RESP returns to IDLE on the next edge; write responses carry rsp_rdata=0.
REQ-032 Minimum transaction: accept at edge N, strobe in cycle N+1; with responder Done in cycle N+3, rsp_valid in cycle N+4.
REQ-033 Back-to-back commands: a new command is accepted no earlier than the cycle after the response handshake.

Reset
REQ-034 While rst_n=0 at a clock edge: state=IDLE; cmd_ready=0 during reset, 1 on the first cycle after release.
REQ-035 While rst_n=0 at a clock edge: rsp_valid=0, rsp_err=0, rsp_rdata=0, VMERdMem=0, VMEWrMem=0, VMEAddr=0, VMEWrData=0, counter=0.
REQ-036 Reset mid-transaction SHALL abort it: strobes low from the next edge, no response issued, late Done pulses ignored.

Verification
REQ-037 32-bit write, addr 0x4, wdata 0x0000_0000_CAFE_F00D, Done 2 cycles after strobe -> one VMEWrMem pulse, VMEAddr=1, VMEWrData=0xCAFEF00D, rsp_err=0.
REQ-038 64-bit read, addr 0x0; responder returns 0x11112222 then 0x33334444 -> VMEAddr 0 then 1, rsp_rdata=0x1111_2222_3333_4444.
REQ-039 64-bit write, addr 0x4 (ADDR_WIDTH=3) -> second strobe wraps to VMEAddr=0; word order 0x4 then 0x0, high half first.
REQ-040 Read, TIMEOUT=4, no Done -> rsp_valid after 4 WAIT cycles, rsp_err=1, rsp_rdata=0; a Done in the TIMEOUT cycle -> rsp_err=0 instead.
REQ-041 Spurious VMEWrDone during a read plus rsp_ready held low 10 cycles -> spurious pulse ignored; response held stable and cmd_ready=0 throughout.
REQ-042 rst_n low during WAIT of a 64-bit write -> no second strobe, no rsp_valid; a subsequent command completes normally.

Source files
------------

// File: rtl/cheby_sbus_master.sv
// Command/response front end for a Cheby SBus-style memory responder.
// Splits 32/64-bit commands into one or two strobed word accesses with a per-word timeout.
module cheby_sbus_master #(
  parameter int ADDR_WIDTH = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic                  cmd_dbl,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [63:0]           cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [63:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:2] VMEAddr,
  output logic [31:0]           VMEWrData,
  input  logic [31:0]           VMERdData,
  output logic                  VMERdMem,
  output logic                  VMEWrMem,
  input  logic                  VMERdDone,
  input  logic                  VMEWrDone
);

  localparam int         WA       = ADDR_WIDTH - 2;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic            started;
  logic            wr_q, dbl_q, second_q, err_q;
  logic [WA-1:0]   addr_q;
  logic [63:0]     wdata_q, rdata_q;
  logic [15:0]     cnt;
  logic            accept, done_hit, timed_out;
  logic            first_of_dbl;

  assign first_of_dbl = dbl_q && !second_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Only the Done matching the latched access type is looked at, and only in WAIT.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    VMEWrMem  = 1'b0;
    VMERdMem  = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    done_hit  = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = started;
        if (cmd_valid && started) begin
          accept    = 1'b1;
          state_nxt = STROBE;
        end
      end
      STROBE: begin
        VMEWrMem  = wr_q;
        VMERdMem  = !wr_q;
        state_nxt = WAIT;
      end
      WAIT: begin
        done_hit = wr_q ? VMEWrDone : VMERdDone;
        if (done_hit) begin
          state_nxt = first_of_dbl ? STROBE : RESP;
        end else if (cnt == CNT_LAST) begin
          timed_out = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data is cleared on accept so skipped halves and write responses read back as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      started  <= 1'b0;
      wr_q     <= 1'b0;
      dbl_q    <= 1'b0;
      second_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt      <= '0;
    end else begin
      started <= 1'b1;
      if (accept) begin
        wr_q     <= cmd_wr;
        dbl_q    <= cmd_dbl;
        second_q <= 1'b0;
        addr_q   <= cmd_addr[ADDR_WIDTH-1:2];
        wdata_q  <= cmd_wdata;
        rdata_q  <= '0;
        err_q    <= 1'b0;
      end
      if (state == STROBE)    cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 16'd1;
      if (done_hit) begin
        if (!wr_q) begin
          if (first_of_dbl) rdata_q[63:32] <= VMERdData;
          else              rdata_q[31:0]  <= VMERdData;
        end
        if (first_of_dbl) begin
          second_q <= 1'b1;
          addr_q   <= addr_q + WA'(1);
        end
      end
      if (timed_out) err_q <= 1'b1;
    end
  end

  assign VMEAddr   = addr_q;
  assign VMEWrData = first_of_dbl ? wdata_q[63:32] : wdata_q[31:0];
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_cheby_sbus_master.sv
// Directed bench for cheby_sbus_master: vector table of full transactions plus
// hand-written reset, spurious-Done and back-pressure sequences.
module tb_cheby_sbus_master;

  localparam int AW = 3;
  localparam int WA = AW - 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_wr, cmd_dbl;
  logic [AW-1:0] cmd_addr;
  logic [63:0]   cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [63:0]   rsp_rdata;
  logic [AW-1:2] VMEAddr;
  logic [31:0]   VMEWrData, VMERdData;
  logic          VMERdMem, VMEWrMem, VMERdDone, VMEWrDone;

  int checks = 0;
  int errors = 0;

  cheby_sbus_master #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_dbl(cmd_dbl),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .VMEAddr(VMEAddr), .VMEWrData(VMEWrData), .VMERdData(VMERdData),
    .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem), .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic          dbl;
    logic [AW-1:0] addr;
    logic [63:0]   wdata;
    int            delay0;   // Done this many cycles after the strobe; 0 = never
    int            delay1;
    logic [31:0]   rd0;
    logic [31:0]   rd1;
    logic [WA-1:0] exp_a0;
    logic [WA-1:0] exp_a1;
    logic [31:0]   exp_wd0;
    logic [31:0]   exp_wd1;
    logic [63:0]   exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkQuiet(input string name);
    checkOutput(name, 64'({VMEWrMem, VMERdMem, rsp_valid}), 64'd0);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int            dly;
    int            nwords;
    bit            to_hit;
    logic [WA-1:0] ea;
    logic [31:0]   ewd;
    logic [31:0]   rd;
    to_hit    = 1'b0;
    nwords    = v.dbl ? 2 : 1;
    cmd_valid = 1'b1;
    cmd_wr    = v.wr;
    cmd_dbl   = v.dbl;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    tick();
    // Scramble the command inputs so only latched values can produce correct outputs.
    cmd_valid = 1'b0;
    cmd_wr    = !v.wr;
    cmd_dbl   = !v.dbl;
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    for (int w = 0; w < nwords; w++) begin
      if (!to_hit) begin
        dly = (w == 0) ? v.delay0 : v.delay1;
        ea  = (w == 0) ? v.exp_a0 : v.exp_a1;
        ewd = (w == 0) ? v.exp_wd0 : v.exp_wd1;
        rd  = (w == 0) ? v.rd0 : v.rd1;
        checkOutput({tag, "_strobe"}, 64'({VMEWrMem, VMERdMem}), v.wr ? 64'd2 : 64'd1);
        checkOutput({tag, "_addr"}, 64'(VMEAddr), 64'(ea));
        if (v.wr) checkOutput({tag, "_wdata"}, 64'(VMEWrData), 64'(ewd));
        if (dly == 0) begin
          for (int d = 1; d <= TO; d++) begin
            tick();
            checkQuiet({tag, "_wait_quiet"});
          end
          tick();
          to_hit = 1'b1;
        end else begin
          for (int d = 1; d <= dly; d++) begin
            tick();
            checkQuiet({tag, "_wait_quiet"});
          end
          checkOutput({tag, "_addr_held"}, 64'(VMEAddr), 64'(ea));
          if (v.wr) checkOutput({tag, "_wdata_held"}, 64'(VMEWrData), 64'(ewd));
          if (v.wr) VMEWrDone = 1'b1;
          else begin
            VMERdDone = 1'b1;
            VMERdData = rd;
          end
          tick();
          VMEWrDone = 1'b0;
          VMERdDone = 1'b0;
          VMERdData = 32'hBAD0_BAD0;
        end
      end
    end
    checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    checkOutput({tag, "_cmd_ready_in_resp"}, 64'(cmd_ready), 64'd0);
    checkOutput({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
    checkOutput({tag, "_rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput({tag, "_back_idle"}, 64'({rsp_valid, cmd_ready}), 64'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //          wr    dbl   addr  wdata                   d0 d1 rd0           rd1           a0    a1    wd0           wd1           rdata                   err
    vecs[0] = '{1'b1, 1'b0, 3'h4, 64'h0000_0000_CAFE_F00D, 2, 0, 32'h0,        32'h0,        1'b1, 1'b0, 32'hCAFE_F00D, 32'h0,        64'h0,                  1'b0};
    vecs[1] = '{1'b0, 1'b1, 3'h0, 64'h0,                   1, 1, 32'h1111_2222, 32'h3333_4444, 1'b0, 1'b1, 32'h0,        32'h0,        64'h1111_2222_3333_4444, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 3'h4, 64'hAAAA_5555_1234_5678, 3, 1, 32'h0,        32'h0,        1'b1, 1'b0, 32'hAAAA_5555, 32'h1234_5678, 64'h0,                  1'b0};
    vecs[3] = '{1'b0, 1'b0, 3'h4, 64'h0,                   4, 0, 32'hDEAD_BEEF, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        64'h0000_0000_DEAD_BEEF, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 3'h0, 64'h0,                   0, 0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        64'h0,                  1'b1};
    vecs[5] = '{1'b0, 1'b1, 3'h4, 64'h0,                   0, 0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        64'h0,                  1'b1};
    vecs[6] = '{1'b1, 1'b0, 3'h3, 64'hFFFF_FFFF_0BAD_F00D, 1, 0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0BAD_F00D, 32'h0,        64'h0,                  1'b0};
    vecs[7] = '{1'b0, 1'b1, 3'h0, 64'h0,                   2, 0, 32'h55AA_55AA, 32'h0,        1'b0, 1'b1, 32'h0,        32'h0,        64'h55AA_55AA_0000_0000, 1'b1};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_dbl   = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    VMERdData = '0;
    VMERdDone = 1'b0;
    VMEWrDone = 1'b0;

    $display("[TB] reset state");
    repeat (3) tick();
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("rst_strobes_rsp", 64'({VMEWrMem, VMERdMem, rsp_valid, rsp_err}), 64'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 64'd0);
    checkOutput("rst_vme_addr", 64'(VMEAddr), 64'd0);
    checkOutput("rst_vme_wrdata", 64'(VMEWrData), 64'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("rel_cmd_ready", 64'(cmd_ready), 64'd1);

    $display("[TB] Done pulses while idle");
    VMERdDone = 1'b1;
    VMEWrDone = 1'b1;
    tick();
    VMERdDone = 1'b0;
    VMEWrDone = 1'b0;
    checkOutput("idle_done_ignored", 64'({rsp_valid, cmd_ready, VMEWrMem, VMERdMem}), 64'h4);

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    $display("[TB] spurious write Done during read, response back-pressure");
    cmd_valid = 1'b1;
    cmd_wr    = 1'b0;
    cmd_dbl   = 1'b0;
    cmd_addr  = 3'h4;
    tick();
    cmd_valid = 1'b0;
    checkOutput("sp_strobe", 64'({VMEWrMem, VMERdMem}), 64'd1);
    tick();
    VMEWrDone = 1'b1;
    tick();
    VMEWrDone = 1'b0;
    checkQuiet("sp_ignored");
    tick();
    VMERdDone = 1'b1;
    VMERdData = 32'h1357_2468;
    tick();
    VMERdDone = 1'b0;
    VMERdData = 32'hBAD0_BAD0;
    for (int c = 0; c < 10; c++) begin
      checkOutput("bp_valid_ready", 64'({rsp_valid, cmd_ready}), 64'd2);
      checkOutput("bp_rdata", rsp_rdata, 64'h0000_0000_1357_2468);
      checkOutput("bp_err", 64'(rsp_err), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("bp_back_idle", 64'({rsp_valid, cmd_ready}), 64'd1);

    $display("[TB] reset during WAIT of a 64-bit write");
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_dbl   = 1'b1;
    cmd_addr  = 3'h0;
    cmd_wdata = 64'h0102_0304_0506_0708;
    tick();
    cmd_valid = 1'b0;
    checkOutput("ab_strobe", 64'({VMEWrMem, VMERdMem}), 64'd2);
    tick();
    rst_n = 1'b0;
    tick();
    checkQuiet("ab_in_reset");
    checkOutput("ab_cmd_ready_in_reset", 64'(cmd_ready), 64'd0);
    rst_n     = 1'b1;
    VMEWrDone = 1'b1;
    tick();
    VMEWrDone = 1'b0;
    checkOutput("ab_cmd_ready_after", 64'(cmd_ready), 64'd1);
    for (int c = 0; c < 5; c++) begin
      checkQuiet("ab_no_second_strobe");
      tick();
    end
    applyStimulus(vecs[2], "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
